posit_unpack_pipe: RTL and testbench

//  Pipelined, parametrised posit decoder: splits an N-bit posit <N,ES> into sign, regime k, exponent and

---
 rtl/posit_pkg.sv | 17 +
 rtl/posit_run_count.sv | 25 ++
 rtl/posit_unpack_pipe.sv | 159 +++++++++++++++
 tb/tb_posit_unpack_pipe.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared posit constants and helpers used by the unpacker and the packer.
package posit_pkg;

  localparam int POSIT_MAX_N = 64;

  localparam logic [POSIT_MAX_N-1:0] POSIT_ZERO = '0;

  // NaR is a lone sign bit: 1 followed by n-1 zeros.
  function automatic logic [POSIT_MAX_N-1:0] POSIT_NAR(input int n);
    return {{(POSIT_MAX_N-1){1'b0}}, 1'b1} << (n - 1);
  endfunction

  function automatic int posit_regime_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/posit_run_count.sv
// Leading-run counter over the N-1 bits below the posit sign: run length of bits equal to the first one.
module posit_run_count #(
  parameter int N = 16,
  localparam int CW = $clog2(N)
) (
  input  logic [N-2:0]  i_bits,
  output logic          o_lead,
  output logic [CW-1:0] o_run
);

  logic w_stop;

  always_comb begin
    o_lead = i_bits[N-2];
    o_run  = '0;
    w_stop = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!w_stop) begin
        if (i_bits[i] == o_lead) o_run = CW'(o_run + 1'b1);
        else                     w_stop = 1'b1;
      end
    end
  end

endmodule

// File: rtl/posit_unpack_pipe.sv
// Two-stage posit decoder with valid/ready on both sides.
// Optional out_scale port (k*2^ES + exp) when POSIT_UNPACK_SCALE_EN is defined.
module posit_unpack_pipe
  import posit_pkg::*;
#(
  parameter int N  = 16,
  parameter int ES = 3,
  localparam int RW = posit_regime_w(N),
  localparam int EW = (ES > 0) ? ES : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sign,
  output logic signed [RW-1:0] out_regime,
  output logic [EW-1:0]        out_exp,
  output logic [N-1:0]         out_frac,
  output logic                 out_zero,
  output logic                 out_nar
`ifdef POSIT_UNPACK_SCALE_EN
  ,
  output logic signed [RW+ES-1:0] out_scale
`endif
);

  localparam int CW = $clog2(N);
  localparam logic [POSIT_MAX_N-1:0] NAR_FULL  = POSIT_NAR(N);
  localparam logic [N-1:0]           NAR       = NAR_FULL[N-1:0];
  localparam logic [N-1:0]           ZERO      = POSIT_ZERO[N-1:0];

  logic                 w_s1_adv, w_s2_adv;
  logic                 r_vld_p1, r_vld_p2;
  logic                 r_sign_p1, r_zero_p1, r_nar_p1;
  logic [N-1:0]         r_abs_p1;
  logic                 r_sign_p2, r_zero_p2, r_nar_p2;
  logic signed [RW-1:0] r_k_p2;
  logic [EW-1:0]        r_exp_p2;
  logic [N-1:0]         r_frac_p2;

  assign w_s2_adv = !r_vld_p2 || out_ready;
  assign w_s1_adv = !r_vld_p1 || w_s2_adv;
  assign in_ready = w_s1_adv;

  // ---- stage 1: sign, magnitude, special-value flags
  logic         w_sign;
  logic [N-1:0] w_abs;

  assign w_sign = in_data[N-1];
  assign w_abs  = w_sign ? (~in_data + 1'b1) : in_data;

  always_ff @(posedge clk) begin
    if (rst)           r_vld_p1 <= 1'b0;
    else if (w_s1_adv) r_vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) begin
      r_sign_p1 <= w_sign;
      r_abs_p1  <= w_abs;
      r_zero_p1 <= (in_data == ZERO);
      r_nar_p1  <= (in_data == NAR);
    end
  end

  // ---- stage 2: regime run, exponent and fraction extraction
  logic                 w_lead;
  logic [CW-1:0]        w_run;
  logic signed [RW-1:0] w_runs, w_k;
  logic [RW-1:0]        w_shamt;
  logic [N-2:0]         w_rest, w_frac_body;
  logic [EW-1:0]        w_exp;
  logic [N-1:0]         w_frac;

  posit_run_count #(.N(N)) u_run (
    .i_bits (r_abs_p1[N-2:0]),
    .o_lead (w_lead),
    .o_run  (w_run)
  );

  assign w_runs  = signed'({1'b0, w_run});
  assign w_k     = w_lead ? (w_runs - RW'(1)) : (RW'(0) - w_runs);
  // Skipping run plus terminator; a shift of N-1 or more empties the word, which zero-pads exp and frac.
  assign w_shamt = RW'(w_run) + RW'(1);
  assign w_rest  = r_abs_p1[N-2:0] << w_shamt;

  generate
    if (ES > 0) begin : g_exp
      assign w_exp = w_rest[N-2 -: EW];
    end else begin : g_noexp
      assign w_exp = '0;
    end
  endgenerate

  assign w_frac_body = w_rest << ES;
  assign w_frac      = {w_frac_body, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p2  <= 1'b0;
      r_sign_p2 <= 1'b0;
      r_zero_p2 <= 1'b0;
      r_nar_p2  <= 1'b0;
      r_k_p2    <= '0;
      r_exp_p2  <= '0;
      r_frac_p2 <= '0;
    end else if (w_s2_adv) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sign_p2 <= r_sign_p1;
        r_zero_p2 <= r_zero_p1;
        r_nar_p2  <= r_nar_p1;
        if (r_zero_p1 || r_nar_p1) begin
          r_k_p2    <= '0;
          r_exp_p2  <= '0;
          r_frac_p2 <= '0;
        end else begin
          r_k_p2    <= w_k;
          r_exp_p2  <= w_exp;
          r_frac_p2 <= w_frac;
        end
      end
    end
  end

`ifdef POSIT_UNPACK_SCALE_EN
  logic signed [RW+ES-1:0] w_scale;
  logic signed [RW+ES-1:0] r_scale_p2;

  // exp < 2^ES, so k*2^ES + exp is just the concatenation {k, exp}.
  generate
    if (ES > 0) begin : g_scale
      assign w_scale = signed'({w_k, w_exp});
    end else begin : g_scale0
      assign w_scale = w_k;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_scale_p2 <= '0;
    else if (w_s2_adv && r_vld_p1)
      r_scale_p2 <= (r_zero_p1 || r_nar_p1) ? '0 : w_scale;
  end

  assign out_scale = r_scale_p2;
`endif

  assign out_valid  = r_vld_p2;
  assign out_sign   = r_sign_p2;
  assign out_regime = r_k_p2;
  assign out_exp    = r_exp_p2;
  assign out_frac   = r_frac_p2;
  assign out_zero   = r_zero_p2;
  assign out_nar    = r_nar_p2;

endmodule

// File: tb/tb_posit_unpack_pipe.sv
// Scoreboard bench for posit_unpack_pipe (N=16, ES=3); checks out_scale when POSIT_UNPACK_SCALE_EN is defined.
module tb_posit_unpack_pipe;

  localparam int N  = 16;
  localparam int ES = 3;
  localparam int RW = 5;

  typedef struct {
    logic [15:0] din;
    logic        sgn;
    int          k;
    logic [2:0]  e;
    logic [15:0] f;
    logic        z;
    logic        nr;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic signed [RW-1:0] out_regime;
  logic [ES-1:0]     out_exp;
  logic [N-1:0]      out_frac;
  logic              out_zero;
  logic              out_nar;
`ifdef POSIT_UNPACK_SCALE_EN
  logic signed [RW+ES-1:0] out_scale;
`endif

  posit_unpack_pipe #(.N(N), .ES(ES)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_regime (out_regime),
    .out_exp    (out_exp),
    .out_frac   (out_frac),
    .out_zero   (out_zero),
    .out_nar    (out_nar)
`ifdef POSIT_UNPACK_SCALE_EN
    ,
    .out_scale  (out_scale)
`endif
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  vec_t stim_q[$];
  vec_t exp_q[$];
  vec_t cur;
  vec_t got;
  logic fire_in = 1'b0;
  int   cyc = 0;
  int   n_acc = 0;
  int   n_out = 0;
  int   acc_cyc = 0;
  int   first_out = -1;
  int   last_out = 0;

  task automatic check(input string nm, input longint act, input longint expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, expv);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL timeout %s", nm);
  endtask

  // Bit-serial reference decode, written from the posit definition.
  function automatic vec_t model(input logic [15:0] x);
    vec_t        r;
    logic [15:0] v;
    int          i, pos, rl;
    logic        ld;
    r.din = x; r.sgn = x[15]; r.z = (x == 16'h0000); r.nr = (x == 16'h8000);
    r.k = 0; r.e = 3'd0; r.f = 16'h0000;
    if (r.z || r.nr) return r;
    v  = x[15] ? (16'h0000 - x) : x;
    ld = v[14];
    i  = 14;
    rl = 0;
    while (i >= 0 && v[i] == ld) begin rl++; i--; end
    r.k = ld ? rl - 1 : -rl;
    i--;
    for (int j = 0; j < 3; j++) begin
      r.e = {r.e[1:0], (i >= 0) ? v[i] : 1'b0};
      i--;
    end
    pos = 15;
    while (i >= 0) begin r.f[pos] = v[i]; pos--; i--; end
    return r;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver: hold a word until accepted, then present the next one immediately.
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      in_valid = 1'b0;
    end else begin
      if (fire_in) in_valid = 1'b0;
      if (!in_valid && stim_q.size() > 0) begin
        cur      = stim_q.pop_front();
        in_data  = cur.din;
        in_valid = 1'b1;
      end
    end
  end

  // Monitor on the falling edge: score outputs, record accepted inputs.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      fire_in = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          got = exp_q.pop_front();
          check("sign",   out_sign, got.sgn);
          check("regime", $signed(out_regime), got.k);
          check("exp",    out_exp, got.e);
          check("frac",   out_frac, got.f);
          check("zero",   out_zero, got.z);
          check("nar",    out_nar, got.nr);
`ifdef POSIT_UNPACK_SCALE_EN
          check("scale",  $signed(out_scale), got.k * 8 + int'(got.e));
`endif
        end
        n_out++;
        last_out = cyc;
        if (first_out < 0) first_out = cyc;
      end
      fire_in = in_valid && in_ready;
      if (fire_in) begin
        exp_q.push_back(cur);
        n_acc++;
        acc_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string nm);
    int guard = 0;
    while ((stim_q.size() > 0 || in_valid || exp_q.size() > 0) && guard < 2000) begin
      step();
      guard++;
    end
    if (guard >= 2000) timeout(nm);
  endtask

  vec_t        tbl[11];
  int          acc0, out0, guard;
  logic [15:0] snap_frac;
  logic [4:0]  snap_k;
  logic [2:0]  snap_e;
  logic        snap_s;

  initial begin
    tbl[0]  = '{16'h73B5, 1'b0,   2, 3'd3, 16'hB500, 1'b0, 1'b0};
    tbl[1]  = '{16'h8C4B, 1'b1,   2, 3'd3, 16'hB500, 1'b0, 1'b0};
    tbl[2]  = '{16'h0003, 1'b0, -13, 3'd4, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{16'h7FFF, 1'b0,  14, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{16'h0000, 1'b0,   0, 3'd0, 16'h0000, 1'b1, 1'b0};
    tbl[5]  = '{16'h8000, 1'b1,   0, 3'd0, 16'h0000, 1'b0, 1'b1};
    tbl[6]  = '{16'h4000, 1'b0,   0, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[7]  = '{16'h0001, 1'b0, -14, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{16'h5A5A, 1'b0,   0, 3'd6, 16'h9680, 1'b0, 1'b0};
    tbl[9]  = '{16'hFFFF, 1'b1, -14, 3'd0, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{16'h3000, 1'b0,  -1, 3'd4, 16'h0000, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_sign",      out_sign, 0);
    check("rst_regime",    out_regime, 0);
    check("rst_exp",       out_exp, 0);
    check("rst_frac",      out_frac, 0);
    check("rst_zero",      out_zero, 0);
    check("rst_nar",       out_nar, 0);

    // Single word: out_valid two cycles after acceptance.
    step();
    first_out = -1;
    stim_q.push_back(tbl[0]);
    wait_idle("latency");
    check("latency", first_out - acc_cyc, 2);

    // Whole table back-to-back: one result per cycle.
    first_out = -1;
    out0 = n_out;
    for (int i = 0; i < 11; i++) stim_q.push_back(tbl[i]);
    wait_idle("table");
    check("table_count", n_out - out0, 11);
    check("throughput", last_out - first_out, 10);

    // Backpressure: three words against a stalled consumer.
    step();
    out_ready = 1'b0;
    acc0 = n_acc;
    out0 = n_out;
    stim_q.push_back(tbl[8]);
    stim_q.push_back(tbl[2]);
    stim_q.push_back(tbl[1]);
    repeat (5) step();
    @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    check("bp_accepted", n_acc - acc0, 2);
    check("bp_out_valid", out_valid, 1);
    snap_frac = out_frac; snap_k = out_regime; snap_e = out_exp; snap_s = out_sign;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_frac", out_frac, snap_frac);
      check("bp_hold_regime", out_regime, snap_k);
      check("bp_hold_exp", out_exp, snap_e);
      check("bp_hold_sign", out_sign, snap_s);
    end
    step();
    out_ready = 1'b1;
    wait_idle("backpressure");
    check("bp_released", n_out - out0, 3);

    // Reset with two words in flight: both are dropped.
    step();
    out_ready = 1'b0;
    acc0 = n_acc;
    stim_q.push_back(tbl[3]);
    stim_q.push_back(tbl[9]);
    guard = 0;
    while (n_acc - acc0 < 2 && guard < 50) begin step(); guard++; end
    if (guard >= 50) timeout("inflight");
    step();
    rst = 1'b1;
    in_valid = 1'b0;
    stim_q.delete();
    step();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out0 = n_out;
    step();
    out_ready = 1'b1;
    repeat (6) step();
    check("mid_rst_no_output", n_out - out0, 0);

    // Random words with random consumer stalls.
    for (int i = 0; i < 300; i++) stim_q.push_back(model(16'($urandom)));
    guard = 0;
    while ((stim_q.size() > 0 || in_valid || exp_q.size() > 0) && guard < 5000) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      guard++;
    end
    if (guard >= 5000) timeout("random");
    out_ready = 1'b1;
    wait_idle("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
